instr_mem_loader: RTL and testbench
===================================

Name: instr_mem_loader

Overview:
- Write-side counterpart of the instruction-memory read path.
- Accepts a byte stream through a valid/ready handshake and assembles big-endian 32-bit MIPS instruction words.
- Writes each word into the instruction memory write port at consecutive word addresses starting at 0.
- Sits between a host/UART byte source and instruction memory. Holds the processor off (busy) until the program is loaded.

Parameters:
- DEPTH, 32, number of 32-bit words in instruction memory.
- AW, 5, word-address width; must equal clog2(DEPTH).

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  one-cycle pulse; begins a load session (ignored unless IDLE or DONE).
- abort  input  1  terminates the session; partial word discarded.
- num_words  input  AW+1  instruction words to load; sampled on accepted start.
- in_data  input  8  stream byte; first byte of a word is bits [31:24].
- in_valid  input  1  in_data valid.
- in_ready  output  1  loader can accept a byte this cycle.
- mem_we  output  1  instruction memory write enable, one-cycle pulse per word.
- mem_addr  output  AW  word address for the write.
- mem_wdata  output  32  assembled instruction.
- busy  output  1  high in LOAD.
- done  output  1  high in DONE until next start or reset.
- error  output  1  num_words > DEPTH on start; valid while done.
- words_written  output  AW+1  count of words written this session.

Behaviour:
- Reset (async, immediate): state IDLE; in_ready=0, mem_we=0, mem_addr=0, mem_wdata=0, busy=0, done=0, error=0, words_written=0. Byte counter=0, shift register=0.
- States:
  - IDLE --start--> LOAD, or DONE if num_words==0 or num_words>DEPTH.
  - LOAD --(words_written==target after final write)--> DONE.
  - LOAD --abort--> IDLE.
  - DONE --start--> as from IDLE.
  - DONE --abort--> IDLE.
- On accepted start:
  - Latch target=num_words; clear words_written, byte counter, error.
  - error=1 only if num_words>DEPTH; then go to DONE with no writes.
- in_ready:
  - 1 only in LOAD and not abort.
  - Deasserted the cycle after the 4th byte of the final word is accepted.
- Byte transfer:
  - Occurs when in_valid && in_ready.
  - Shift: word <= {word[23:0], in_data}; byte counter increments mod 4.
- Word write:
  - In the cycle after the 4th byte is accepted: mem_we=1, mem_addr=words_written[AW-1:0], mem_wdata=assembled word.
  - words_written increments on that same edge.
  - Latency from last byte accepted to write pulse: 1 cycle.
- Throughput: back-to-back bytes allowed every cycle, including across word boundaries; in_ready stays high.
- mem_addr and mem_wdata hold their last values when mem_we=0.
- Final word: the state moves to DONE on the edge that issues the final mem_we.
  - done=1 the cycle after the final write pulse.
  - busy drops at the same time.
- Abort priority:
  - abort beats start and byte acceptance in the same cycle.
  - A pending write (4th byte accepted the previous cycle) still completes; then IDLE.
- start during LOAD: ignored.
- in_valid outside LOAD: ignored, no side effects.
- Address never wraps: at most target<=DEPTH words are written.

Optional Feature:
- Macro LOADER_CHECKSUM_EN.
- When defined, adds ports:
  - expected_sum input 32, sampled with num_words.
  - sum_ok output 1.
- A running XOR of every written mem_wdata is kept and cleared on start.
- On entry to DONE (non-error): sum_ok = (xor == expected_sum); sum_ok reset value 0.
- Without the macro: no extra ports or logic; behaviour otherwise identical.

Decomposition:
- Shared package mips_loader_pkg:
  - State enum {LD_IDLE, LD_LOAD, LD_DONE}.
  - Localparams BYTES_PER_WORD=4 and WORD_W=32.
- One natural sub-module, byte_word_packer:
  - Shift register plus mod-4 counter.
  - Emits word_valid one cycle after the 4th byte.
  - Controller FSM in the top.

Test Plan:
- Reset mid-LOAD after 6 bytes -> all outputs 0 immediately; no mem_we afterward; IDLE.
- start, num_words=2, bytes 20 08 00 05 8C 09 00 04 streamed back-to-back:
  - mem_we at addr 0 data 0x20080005, then addr 1 data 0x8C090004.
  - done=1, words_written=2, error=0.
- num_words=0 -> DONE next cycle, no writes; num_words=33 (DEPTH=32) -> done=1, error=1, no writes.
- in_valid toggled 1/0 every cycle, num_words=1, bytes AA BB CC DD -> single write 0xAABBCCDD, one cycle after the 4th accepted byte.
- abort asserted after 5 bytes of num_words=3 -> exactly one write (addr 0), IDLE, in_ready=0; a new start restarts at addr 0.
- LOADER_CHECKSUM_EN, words 0x11111111 and 0x22222222:
  - expected_sum=0x33333333 -> sum_ok=1.
  - expected_sum=0 -> sum_ok=0.

Source files
------------

// File: rtl/instr_mem_loader_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mips_loader_pkg
// Purpose  : Shared types and constants for the instruction-memory loader:
//            controller state encoding and instruction word geometry.
// Ports    : none (package)
// Options  : LOADER_CHECKSUM_EN (used by instr_mem_loader, not here)
// Revision : 1.0 - initial release
// ============================================================================
package mips_loader_pkg;

    localparam int BYTES_PER_WORD = 4;
    localparam int WORD_W         = 32;
    localparam int BCNT_W         = $clog2(BYTES_PER_WORD);

    typedef enum logic [1:0] {
        LD_IDLE = 2'd0,
        LD_LOAD = 2'd1,
        LD_DONE = 2'd2
    } ld_state_t;

endpackage
`default_nettype wire

// File: rtl/instr_mem_loader_if.sv
`default_nettype none
// ============================================================================
// Module   : instr_mem_loader_if
// Purpose  : Groups the byte-stream handshake (in_data/in_valid/in_ready)
//            and the instruction-memory write port (mem_we/mem_addr/
//            mem_wdata) seen by the loader.
// Modports : slave  - the loader (consumes bytes, drives memory writes)
//            master - the host/memory side (drives bytes, observes writes)
// Revision : 1.0 - initial release
// ============================================================================
interface instr_mem_loader_if
    import mips_loader_pkg::*;
#(
    parameter int AW = 5
);
    logic [7:0]        in_data;
    logic              in_valid;
    logic              in_ready;
    logic              mem_we;
    logic [AW-1:0]     mem_addr;
    logic [WORD_W-1:0] mem_wdata;

    modport slave (
        input  in_data, in_valid,
        output in_ready, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output in_data, in_valid,
        input  in_ready, mem_we, mem_addr, mem_wdata
    );
endinterface
`default_nettype wire

// File: rtl/instr_mem_loader_packer.sv
`default_nettype none
// ============================================================================
// Module   : byte_word_packer
// Purpose  : Assembles big-endian 32-bit words from a byte stream. The first
//            byte of a word lands in bits [31:24].
// Ports    : clk, reset     - clock, asynchronous active-high reset
//            i_clr          - discard any partial word
//            i_byte_en      - a byte is transferred this cycle
//            i_byte         - the byte being transferred
//            o_word_done    - this transfer completes a word (combinational)
//            o_word_valid   - one-cycle pulse the cycle after a word completes
//            o_word         - last completed word, held until the next one
// Revision : 1.0 - initial release
// ============================================================================
module byte_word_packer
    import mips_loader_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              i_clr,
    input  logic              i_byte_en,
    input  logic [7:0]        i_byte,
    output logic              o_word_done,
    output logic              o_word_valid,
    output logic [WORD_W-1:0] o_word
);

    localparam logic [BCNT_W-1:0] c_last_byte = BCNT_W'(BYTES_PER_WORD - 1);

    logic [BCNT_W-1:0] r_cnt;
    // Only the first three bytes need holding; the fourth goes straight
    // into the output word register.
    logic [WORD_W-9:0] r_shift;
    logic              r_word_valid;
    logic [WORD_W-1:0] r_word;

    assign o_word_done  = i_byte_en && (r_cnt == c_last_byte);
    assign o_word_valid = r_word_valid;
    assign o_word       = r_word;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt        <= '0;
            r_shift      <= '0;
            r_word_valid <= 1'b0;
            r_word       <= '0;
        end else begin
            r_word_valid <= o_word_done && !i_clr;
            if (i_clr) begin
                r_cnt   <= '0;
                r_shift <= '0;
            end else if (i_byte_en) begin
                r_cnt   <= r_cnt + 1'b1;
                r_shift <= {r_shift[WORD_W-17:0], i_byte};
            end
            if (o_word_done && !i_clr) begin
                r_word <= {r_shift, i_byte};
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/instr_mem_loader.sv
`default_nettype none
// ============================================================================
// Module   : instr_mem_loader
// Purpose  : Loads a program into instruction memory from a byte stream.
//            Bytes are packed big-endian into 32-bit words and written to
//            consecutive word addresses from 0. busy holds the processor
//            off while loading; done flags a completed session.
// Ports    : clk, reset       - clock, asynchronous active-high reset
//            start, abort     - session control (abort has priority)
//            num_words        - words to load, sampled on accepted start
//            bus (slave)      - byte stream in, memory write port out
//            busy, done       - session status
//            error            - num_words exceeded DEPTH at start
//            words_written    - words written this session
//            expected_sum,    - (LOADER_CHECKSUM_EN only) XOR checksum of
//            sum_ok             all written words compared on completion
// Options  : LOADER_CHECKSUM_EN - adds the XOR checksum ports and logic
// Revision : 1.0 - initial release
// ============================================================================
module instr_mem_loader
    import mips_loader_pkg::*;
#(
    parameter int DEPTH = 32,
    parameter int AW    = 5
)
(
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              abort,
    input  logic [AW:0]       num_words,
`ifdef LOADER_CHECKSUM_EN
    input  logic [WORD_W-1:0] expected_sum,
    output logic              sum_ok,
`endif
    instr_mem_loader_if.slave bus,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [AW:0]       words_written
);

    localparam logic [AW:0] c_depth = (AW+1)'(DEPTH);

    ld_state_t         r_state;
    ld_state_t         w_next_state;

    logic [AW:0]       r_target;
    logic [AW:0]       r_words_written;
    logic              r_error;
    logic [AW-1:0]     r_mem_addr;

    logic              w_start_acc;
    logic              w_start_err;
    logic              w_start_empty;
    logic              w_last;
    logic              w_in_ready;
    logic              w_byte_acc;
    logic              w_clr;
    logic              w_word_done;
    logic              w_word_valid;
    logic [WORD_W-1:0] w_word;

    // Start is only honoured outside LOAD, and abort overrides it.
    assign w_start_acc   = start && !abort && (r_state != LD_LOAD);
    assign w_start_err   = num_words > c_depth;
    assign w_start_empty = (num_words == '0);
    // True while the write in flight is the final word of the session.
    assign w_last        = ((r_words_written + 1'b1) == r_target);
    assign w_byte_acc    = bus.in_valid && w_in_ready;
    assign w_clr         = w_start_acc || abort;

    byte_word_packer u_packer (
        .clk          (clk),
        .reset        (reset),
        .i_clr        (w_clr),
        .i_byte_en    (w_byte_acc),
        .i_byte       (bus.in_data),
        .o_word_done  (w_word_done),
        .o_word_valid (w_word_valid),
        .o_word       (w_word)
    );

    // ---------------------------------------------------------------- FSM
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= LD_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            LD_IDLE, LD_DONE: begin
                if (abort) begin
                    w_next_state = LD_IDLE;
                end else if (start) begin
                    w_next_state = (w_start_empty || w_start_err) ? LD_DONE : LD_LOAD;
                end
            end
            LD_LOAD: begin
                // A write already in flight completes even when aborting;
                // abort only decides where the session ends up.
                if (abort) begin
                    w_next_state = LD_IDLE;
                end else if (w_word_valid && w_last) begin
                    w_next_state = LD_DONE;
                end
            end
            default: w_next_state = LD_IDLE;
        endcase
    end

    always_comb begin
        w_in_ready = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        case (r_state)
            LD_LOAD: begin
                busy       = 1'b1;
                // Stop accepting once the final word is complete, so no
                // byte is taken that would never be written.
                w_in_ready = !abort && !(w_word_valid && w_last);
            end
            LD_DONE: done = 1'b1;
            default: ;
        endcase
    end

    // ----------------------------------------------------------- datapath
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_target        <= '0;
            r_words_written <= '0;
            r_error         <= 1'b0;
            r_mem_addr      <= '0;
        end else begin
            if (w_start_acc) begin
                r_target        <= num_words;
                r_words_written <= '0;
                r_error         <= w_start_err;
            end else if (w_word_valid) begin
                r_words_written <= r_words_written + 1'b1;
            end
            // Address is captured with the word so both hold between writes.
            if (w_word_done) begin
                r_mem_addr <= r_words_written[AW-1:0];
            end
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.mem_we    = w_word_valid;
    assign bus.mem_addr  = r_mem_addr;
    assign bus.mem_wdata = w_word;
    assign words_written = r_words_written;
    assign error         = r_error;

`ifdef LOADER_CHECKSUM_EN
    logic [WORD_W-1:0] r_expected;
    logic [WORD_W-1:0] r_xor;
    logic [WORD_W-1:0] w_xor_next;
    logic              r_sum_ok;

    assign w_xor_next = r_xor ^ w_word;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_expected <= '0;
            r_xor      <= '0;
            r_sum_ok   <= 1'b0;
        end else begin
            if (w_start_acc) begin
                r_xor      <= '0;
                r_expected <= expected_sum;
                // An empty session completes immediately with a zero sum;
                // an oversize request never reports a good sum.
                r_sum_ok   <= w_start_empty && (expected_sum == '0);
            end else begin
                if (w_word_valid) begin
                    r_xor <= w_xor_next;
                end
                if ((r_state == LD_LOAD) && (w_next_state == LD_DONE)) begin
                    r_sum_ok <= (w_xor_next == r_expected);
                end
            end
        end
    end

    assign sum_ok = r_sum_ok;
`endif

endmodule
`default_nettype wire

// File: tb/tb_instr_mem_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_instr_mem_loader
// Purpose  : Directed self-checking bench for instr_mem_loader. Writes and
//            byte acceptances are logged at the falling edge and compared
//            against hand-computed values.
// Revision : 1.0 - initial release
// ============================================================================
module tb_instr_mem_loader;

    localparam int DEPTH = 32;
    localparam int AW    = 5;

    logic          clk       = 1'b0;
    logic          reset     = 1'b1;
    logic          start     = 1'b0;
    logic          abort     = 1'b0;
    logic [AW:0]   num_words = '0;
    logic          busy;
    logic          done;
    logic          error;
    logic [AW:0]   words_written;
`ifdef LOADER_CHECKSUM_EN
    logic [31:0]   expected_sum = '0;
    logic          sum_ok;
`endif

    instr_mem_loader_if #(.AW(AW)) bus ();

    instr_mem_loader #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk           (clk),
        .reset         (reset),
        .start         (start),
        .abort         (abort),
        .num_words     (num_words),
`ifdef LOADER_CHECKSUM_EN
        .expected_sum  (expected_sum),
        .sum_ok        (sum_ok),
`endif
        .bus           (bus),
        .busy          (busy),
        .done          (done),
        .error         (error),
        .words_written (words_written)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Logs of memory writes and accepted bytes (cycle numbers included).
    int          wr_cyc[$];
    logic [31:0] wr_addr[$];
    logic [31:0] wr_data[$];
    int          acc_cyc[$];

    always @(negedge clk) begin
        if (!reset && bus.mem_we) begin
            wr_cyc.push_back(cyc);
            wr_addr.push_back(32'(bus.mem_addr));
            wr_data.push_back(bus.mem_wdata);
        end
        if (!reset && bus.in_valid && bus.in_ready) begin
            acc_cyc.push_back(cyc);
        end
    end

    function automatic logic [31:0] wa(int i);
        return (i < wr_addr.size()) ? wr_addr[i] : 32'hDEAD_BEEF;
    endfunction
    function automatic logic [31:0] wd(int i);
        return (i < wr_data.size()) ? wr_data[i] : 32'hDEAD_BEEF;
    endfunction
    function automatic int wc(int i);
        return (i < wr_cyc.size()) ? wr_cyc[i] : -100;
    endfunction
    function automatic int ac(int i);
        return (i < acc_cyc.size()) ? acc_cyc[i] : -1000;
    endfunction

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input int n);
        num_words = (AW+1)'(n);
        start     = 1'b1;
        tick();
        start     = 1'b0;
    endtask

    logic [7:0] tx_q[$];

    // Streams tx_q; with gap set, in_valid toggles 1/0 every cycle.
    task automatic send_all(input bit gap);
        int  guard = 0;
        bit  accepted;
        while (tx_q.size() > 0 && guard < 200) begin
            bus.in_valid = 1'b1;
            bus.in_data  = tx_q[0];
            @(negedge clk);
            accepted = bus.in_ready;
            tick();
            if (accepted) void'(tx_q.pop_front());
            if (gap) begin
                bus.in_valid = 1'b0;
                tick();
            end
            guard++;
        end
        bus.in_valid = 1'b0;
        if (guard >= 200) check("send_timeout", 32'(tx_q.size()), 32'd0);
        tx_q.delete();
    endtask

    int mw;
    int ma;

    initial begin
        bus.in_data  = 8'h00;
        bus.in_valid = 1'b0;

        // ---------------- reset state
        repeat (3) tick();
        @(negedge clk);
        check("rst_in_ready", 32'(bus.in_ready), 32'd0);
        check("rst_mem_we",   32'(bus.mem_we), 32'd0);
        check("rst_addr",     32'(bus.mem_addr), 32'd0);
        check("rst_wdata",    bus.mem_wdata, 32'd0);
        check("rst_busy",     32'(busy), 32'd0);
        check("rst_done",     32'(done), 32'd0);
        check("rst_error",    32'(error), 32'd0);
        check("rst_ww",       32'(words_written), 32'd0);
        reset = 1'b0;
        tick();

        // ---------------- reset mid-LOAD after 6 bytes
        mw = wr_addr.size();
        do_start(2);
        tx_q = {8'h20, 8'h08, 8'h00, 8'h05, 8'h8C, 8'h09};
        send_all(1'b0);
        check("midrst_pre_writes", 32'(wr_addr.size() - mw), 32'd1);
        check("midrst_pre_wdata",  bus.mem_wdata, 32'h2008_0005);
        check("midrst_pre_busy",   32'(busy), 32'd1);
        #2 reset = 1'b1;
        #1;
        check("midrst_wdata",    bus.mem_wdata, 32'd0);
        check("midrst_busy",     32'(busy), 32'd0);
        check("midrst_in_ready", 32'(bus.in_ready), 32'd0);
        check("midrst_ww",       32'(words_written), 32'd0);
        check("midrst_mem_we",   32'(bus.mem_we), 32'd0);
        repeat (2) tick();
        reset = 1'b0;
        repeat (4) tick();
        @(negedge clk);
        check("midrst_post_writes", 32'(wr_addr.size() - mw), 32'd1);
        check("midrst_post_busy",   32'(busy), 32'd0);
        check("midrst_post_done",   32'(done), 32'd0);

        // ---------------- two words back-to-back
        mw = wr_addr.size();
        ma = acc_cyc.size();
        do_start(2);
        tx_q = {8'h20, 8'h08, 8'h00, 8'h05, 8'h8C, 8'h09, 8'h00, 8'h04};
        send_all(1'b0);
        @(negedge clk);
        check("b2b_final_we",    32'(bus.mem_we), 32'd1);
        check("b2b_final_ready", 32'(bus.in_ready), 32'd0);
        check("b2b_final_done",  32'(done), 32'd0);
        check("b2b_final_busy",  32'(busy), 32'd1);
        tick();
        @(negedge clk);
        check("b2b_done",      32'(done), 32'd1);
        check("b2b_busy",      32'(busy), 32'd0);
        check("b2b_we_low",    32'(bus.mem_we), 32'd0);
        check("b2b_ww",        32'(words_written), 32'd2);
        check("b2b_error",     32'(error), 32'd0);
        check("b2b_hold_addr", 32'(bus.mem_addr), 32'd1);
        check("b2b_hold_data", bus.mem_wdata, 32'h8C09_0004);
        check("b2b_nwrites",   32'(wr_addr.size() - mw), 32'd2);
        check("b2b_addr0",     wa(mw), 32'd0);
        check("b2b_data0",     wd(mw), 32'h2008_0005);
        check("b2b_addr1",     wa(mw + 1), 32'd1);
        check("b2b_data1",     wd(mw + 1), 32'h8C09_0004);
        check("b2b_lat0",      32'(wc(mw) - ac(ma + 3)), 32'd1);
        check("b2b_lat1",      32'(wc(mw + 1) - ac(ma + 7)), 32'd1);
        check("b2b_span",      32'(ac(ma + 7) - ac(ma)), 32'd7);

        // ---------------- empty and oversize sessions
        mw = wr_addr.size();
        ma = acc_cyc.size();
        do_start(0);
        @(negedge clk);
        check("zero_done",  32'(done), 32'd1);
        check("zero_error", 32'(error), 32'd0);
        check("zero_busy",  32'(busy), 32'd0);
        check("zero_ww",    32'(words_written), 32'd0);
        tick();
        do_start(33);
        @(negedge clk);
        check("over_done",  32'(done), 32'd1);
        check("over_error", 32'(error), 32'd1);
        check("over_busy",  32'(busy), 32'd0);
        bus.in_valid = 1'b1;
        bus.in_data  = 8'h5A;
        repeat (3) tick();
        bus.in_valid = 1'b0;
        @(negedge clk);
        check("over_ready",    32'(bus.in_ready), 32'd0);
        check("over_noaccept", 32'(acc_cyc.size() - ma), 32'd0);
        check("over_nowrites", 32'(wr_addr.size() - mw), 32'd0);

        // ---------------- in_valid toggling, single word
        mw = wr_addr.size();
        ma = acc_cyc.size();
        do_start(1);
        tx_q = {8'hAA, 8'hBB, 8'hCC, 8'hDD};
        send_all(1'b1);
        @(negedge clk);
        check("tog_nwrites", 32'(wr_addr.size() - mw), 32'd1);
        check("tog_addr",    wa(mw), 32'd0);
        check("tog_data",    wd(mw), 32'hAABB_CCDD);
        check("tog_lat",     32'(wc(mw) - ac(ma + 3)), 32'd1);
        check("tog_span",    32'(ac(ma + 3) - ac(ma)), 32'd6);
        check("tog_done",    32'(done), 32'd1);
        check("tog_error",   32'(error), 32'd0);
        check("tog_ww",      32'(words_written), 32'd1);

        // ---------------- abort after 5 bytes of 3 words
        mw = wr_addr.size();
        ma = acc_cyc.size();
        do_start(3);
        tx_q = {8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
        send_all(1'b0);
        abort        = 1'b1;
        start        = 1'b1;
        bus.in_valid = 1'b1;
        bus.in_data  = 8'h66;
        @(negedge clk);
        check("abort_ready_now", 32'(bus.in_ready), 32'd0);
        tick();
        abort        = 1'b0;
        start        = 1'b0;
        bus.in_valid = 1'b0;
        repeat (3) tick();
        @(negedge clk);
        check("abort_busy",     32'(busy), 32'd0);
        check("abort_done",     32'(done), 32'd0);
        check("abort_ready",    32'(bus.in_ready), 32'd0);
        check("abort_ww",       32'(words_written), 32'd1);
        check("abort_nwrites",  32'(wr_addr.size() - mw), 32'd1);
        check("abort_addr",     wa(mw), 32'd0);
        check("abort_data",     wd(mw), 32'h1122_3344);
        check("abort_naccept",  32'(acc_cyc.size() - ma), 32'd5);
        mw = wr_addr.size();
        do_start(1);
        tx_q = {8'h01, 8'h02, 8'h03, 8'h04};
        send_all(1'b0);
        tick();
        @(negedge clk);
        check("restart_done",    32'(done), 32'd1);
        check("restart_nwrites", 32'(wr_addr.size() - mw), 32'd1);
        check("restart_addr",    wa(mw), 32'd0);
        check("restart_data",    wd(mw), 32'h0102_0304);

`ifdef LOADER_CHECKSUM_EN
        // ---------------- checksum
        expected_sum = 32'h3333_3333;
        do_start(2);
        tx_q = {8'h11, 8'h11, 8'h11, 8'h11, 8'h22, 8'h22, 8'h22, 8'h22};
        send_all(1'b0);
        tick();
        @(negedge clk);
        check("sum_good_done", 32'(done), 32'd1);
        check("sum_good_ok",   32'(sum_ok), 32'd1);
        expected_sum = 32'h0000_0000;
        do_start(2);
        tx_q = {8'h11, 8'h11, 8'h11, 8'h11, 8'h22, 8'h22, 8'h22, 8'h22};
        send_all(1'b0);
        tick();
        @(negedge clk);
        check("sum_bad_done", 32'(done), 32'd1);
        check("sum_bad_ok",   32'(sum_ok), 32'd0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
